dram_arbiter: RTL and testbench

- Shares the single DRAM port (16-bit address, 8-bit data) among NUM_CORES matrix-multiplier cores in the multi-core top level.
- Round-robin arbitration with a bounded hold, so one core can burst up to MAX_HOLD consecutive accesses before it must release the port.
- Muxes the granted core's address, data and strobes onto the DRAM port.
- Routes DRAM read data back to the core that issued each read, tagged READ_LAT cycles later.

---
 rtl/dram_arbiter.sv | 144 ++++++++++++++
 tb/tb_dram_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Round-robin, bounded-hold arbiter sharing one DRAM port among several cores.
// Read data is steered back to the issuing core after a fixed read latency.
module dram_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned MAX_HOLD  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CORES-1:0]          i_req,
    input  logic [NUM_CORES-1:0]          i_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   i_wdata,
    output logic [NUM_CORES-1:0]          o_gnt,
    output logic [NUM_CORES-1:0]          o_rvalid,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [ADDR_W-1:0]             o_dram_addr,
    output logic [DATA_W-1:0]             o_dram_data,
    output logic                          o_dram_read,
    output logic                          o_dram_write,
    input  logic [DATA_W-1:0]             i_dram_q,
    output logic                          o_busy
);

    localparam int unsigned IdW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
    localparam logic [NUM_CORES-1:0] OneCore = {{(NUM_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StArb, StOwn} state_e;

    state_e               state_q;
    logic [NUM_CORES-1:0] gnt_q;
    logic [IdW-1:0]       own_q;
    logic [IdW-1:0]       ptr_q;
    logic [7:0]           hold_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic [READ_LAT-1:0]  pipe_vld_q;
    logic [IdW-1:0]       pipe_id_q [READ_LAT];

    logic                 access;
    logic                 acc_we;
    logic [ADDR_W-1:0]    acc_addr;
    logic [DATA_W-1:0]    acc_data;
    logic                 sel_found;
    logic [IdW-1:0]       sel_id;

    function automatic logic [IdW-1:0] wrap_id(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return s[IdW-1:0];
    endfunction

    // gnt_q is one-hot in OWN and zero in ARB, so it doubles as the access mux select.
    always_comb begin
        acc_addr = '0;
        acc_data = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (gnt_q[k]) begin
                acc_addr = i_addr[k*ADDR_W +: ADDR_W];
                acc_data = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign access = |(gnt_q & i_req);
    assign acc_we = |(gnt_q & i_we);

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!sel_found && i_req[wrap_id(32'(ptr_q), unsigned'(i))]) begin
                sel_found = 1'b1;
                sel_id    = wrap_id(32'(ptr_q), unsigned'(i));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StArb;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (access) begin
                addr_q <= acc_addr;
                data_q <= acc_data;
            end
            unique case (state_q)
                StArb: begin
                    if (sel_found) begin
                        gnt_q   <= OneCore << sel_id;
                        own_q   <= sel_id;
                        hold_q  <= '0;
                        state_q <= StOwn;
                    end
                end
                StOwn: begin
                    if (!access || hold_q == HoldLast) begin
                        gnt_q   <= '0;
                        ptr_q   <= wrap_id(32'(own_q), 32'd1);
                        state_q <= StArb;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    // Each stage carries {valid, core id} of one read access toward its data return.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) pipe_id_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= access & ~acc_we;
            pipe_id_q[0]  <= own_q;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    assign o_gnt        = gnt_q;
    assign o_rvalid     = pipe_vld_q[READ_LAT-1] ? (OneCore << pipe_id_q[READ_LAT-1]) : '0;
    assign o_rdata      = i_dram_q;
    assign o_dram_addr  = access ? acc_addr : addr_q;
    assign o_dram_data  = access ? acc_data : data_q;
    assign o_dram_read  = access & ~acc_we;
    assign o_dram_write = access & acc_we;
    assign o_busy       = (|gnt_q) | (|pipe_vld_q);

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: reset, single read, write/early release, round-robin with
// read handoff, hold limit with wrap-around regrant, and reset during an in-flight read.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata, dram_data, dram_q;
    logic [15:0] dram_addr;
    logic        dram_read, dram_write, busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dram_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_gnt        (gnt),
        .o_rvalid     (rvalid),
        .o_rdata      (rdata),
        .o_dram_addr  (dram_addr),
        .o_dram_data  (dram_data),
        .o_dram_read  (dram_read),
        .o_dram_write (dram_write),
        .i_dram_q     (dram_q),
        .o_busy       (busy)
    );

    // DRAM model: one-cycle read latency; unwritten locations read as addr[7:0]^0x4A.
    logic [7:0] mem [0:65535];
    bit         wr_seen [0:65535];
    always @(posedge clk) begin
        if (dram_write) begin
            mem[dram_addr]     <= dram_data;
            wr_seen[dram_addr] <= 1'b1;
        end
        if (dram_read)
            dram_q <= wr_seen[dram_addr] ? mem[dram_addr] : (dram_addr[7:0] ^ 8'h4A);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;

        // Reset state
        cyc(); smp();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rd_wr", 32'({dram_read, dram_write}), 32'h0);
        check("rst_addr", 32'(dram_addr), 32'h0);
        check("rst_data", 32'(dram_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Single requester: core 0 reads 0x0010 (model holds 0x5A there)
        cyc(); rst = 1'b0; req = 4'b0001; addr[15:0] = 16'h0010; smp();
        check("b_arb_gnt", 32'(gnt), 32'h0);
        cyc(); smp();
        check("b_gnt", 32'(gnt), 32'h1);
        check("b_read", 32'(dram_read), 32'h1);
        check("b_addr", 32'(dram_addr), 32'h0010);
        check("b_busy", 32'(busy), 32'h1);
        cyc(); req = 4'b0000; smp();
        check("b_rvalid", 32'(rvalid), 32'h1);
        check("b_rdata", 32'(rdata), 32'h5A);
        check("b_idle_read", 32'(dram_read), 32'h0);
        check("b_addr_hold", 32'(dram_addr), 32'h0010);
        check("b_busy2", 32'(busy), 32'h1);

        // Core 1 writes 0xA5 to 0x1234 then drops request
        cyc(); req = 4'b0010; we = 4'b0010; addr[31:16] = 16'h1234; wdata[15:8] = 8'hA5; smp();
        check("c_rel_gnt", 32'(gnt), 32'h0);
        check("c_rel_busy", 32'(busy), 32'h0);
        check("c_rel_rvalid", 32'(rvalid), 32'h0);
        cyc(); smp();
        check("c_gnt", 32'(gnt), 32'h2);
        check("c_write", 32'({dram_read, dram_write}), 32'h1);
        check("c_addr", 32'(dram_addr), 32'h1234);
        check("c_data", 32'(dram_data), 32'hA5);
        cyc(); req = 4'b0000; smp();
        check("c_nowrite", 32'(dram_write), 32'h0);
        check("c_no_rvalid", 32'(rvalid), 32'h0);

        // Core 3 reads back 0x1234
        cyc(); req = 4'b1000; we = 4'b0000; addr[63:48] = 16'h1234; smp();
        check("d_arb_gnt", 32'(gnt), 32'h0);
        cyc(); smp();
        check("d_gnt", 32'(gnt), 32'h8);
        check("d_read", 32'(dram_read), 32'h1);
        cyc(); req = 4'b0000; smp();
        check("d_rvalid", 32'(rvalid), 32'h8);
        check("d_rdata", 32'(rdata), 32'hA5);

        // Round-robin, all cores reading: pointer is 0 so order is 0,1,2,3,0
        cyc(); req = 4'b1111;
        addr = {16'h0400, 16'h0300, 16'h0200, 16'h0100}; smp();
        check("e_arb_gnt", 32'(gnt), 32'h0);
        check("e_arb_rvalid", 32'(rvalid), 32'h0);
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 8; j++) begin
                cyc(); smp();
                check("e_gnt", 32'(gnt), 32'(1) << (r % 4));
                check("e_read", 32'(dram_read), 32'h1);
                check("e_addr", 32'(dram_addr), 32'h0100 * ((r % 4) + 1));
                check("e_rvalid", 32'(rvalid), (j == 0) ? 32'h0 : (32'(1) << (r % 4)));
            end
            cyc(); if (r == 4) req = 4'b0000; smp();
            check("e_hand_gnt", 32'(gnt), 32'h0);
            check("e_hand_rvalid", 32'(rvalid), 32'(1) << (r % 4));
            check("e_hand_busy", 32'(busy), 32'h1);
        end

        // Hold limit: core 2 alone writes; pointer 1 selects core 2
        cyc(); req = 4'b0100; we = 4'b0100; smp();
        check("f_arb_gnt", 32'(gnt), 32'h0);
        for (int j = 0; j < 8; j++) begin
            cyc(); addr[47:32] = 16'h0200 + 16'(j); wdata[23:16] = 8'h30 + 8'(j); smp();
            check("f_gnt", 32'(gnt), 32'h4);
            check("f_write", 32'(dram_write), 32'h1);
            check("f_addr", 32'(dram_addr), 32'h0200 + 32'(j));
            check("f_data", 32'(dram_data), 32'h30 + 32'(j));
        end
        cyc(); smp();
        check("f_rel_gnt", 32'(gnt), 32'h0);
        check("f_rel_write", 32'(dram_write), 32'h0);

        // Regrant of core 2 (pointer 3 wraps); read access with reset taken at its edge
        cyc(); we = 4'b0000; rst = 1'b1; smp();
        check("g_regrant", 32'(gnt), 32'h4);
        check("g_read", 32'(dram_read), 32'h1);
        cyc(); rst = 1'b0; req = 4'b1111; smp();
        check("g_rvalid", 32'(rvalid), 32'h0);
        check("g_gnt", 32'(gnt), 32'h0);
        check("g_busy", 32'(busy), 32'h0);
        cyc(); smp();
        check("g_after_rst_gnt", 32'(gnt), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
